pipe_stage_reg: RTL and testbench



---
 rtl/pipe_pkg.sv | 13 +
 rtl/pipe_skid_entry.sv | 41 ++++
 rtl/pipe_stage_reg.sv | 99 +++++++++
 tb/tb_pipe_stage_reg.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline boundary registers: per-boundary payload
// widths, the bubble encoding and the performance counter width.
package pipe_pkg;

  localparam int IF_ID_W  = 64;   // PC + instruction
  localparam int ID_EX_W  = 128;
  localparam int EX_MEM_W = 96;
  localparam int MEM_WB_W = 72;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam int          PERF_CNT_W = 32;

endpackage

// File: rtl/pipe_skid_entry.sv
// One valid+data register slot with clear (to bubble), load and drop controls.
// Priority: clear > load > drop > hold.
module pipe_skid_entry
  import pipe_pkg::*;
#(
  parameter int                DATA_W = IF_ID_W,
  parameter logic [DATA_W-1:0] BUBBLE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic              i_drop,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  // Dropping only clears valid; the data stays visible as the last payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= BUBBLE;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_data  <= BUBBLE;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_drop) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register with valid/ready handshake and a 2-entry skid
// (main + skid), freeze and flush. Optional counters: PIPE_STAGE_REG_PERF_EN.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W = IF_ID_W,
  parameter int                N_FRZ  = 2,
  parameter logic [DATA_W-1:0] BUBBLE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [N_FRZ-1:0]  freeze,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_REG_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_stall_cnt,
  output logic [PERF_CNT_W-1:0] perf_flush_cnt,
  output logic                  perf_bubble
`endif
);

  // Handshake: a transfer happens on a side only when valid & ready are both
  // high at a rising edge. in_ready never looks at out_ready; it depends only
  // on registered skid occupancy and the freeze inputs.
  logic              w_frz, w_adv;
  logic              w_in_fire, w_out_fire, w_main_free;
  logic              w_main_v, w_skid_v;
  logic [DATA_W-1:0] w_main_d, w_skid_d, w_main_in;
  logic              w_main_load, w_main_drop, w_skid_load, w_skid_drop;

  assign w_frz       = |freeze;
  assign w_adv       = ~flush & ~w_frz;
  assign in_ready    = ~w_skid_v & ~w_frz;
  assign w_in_fire   = in_valid & in_ready & ~flush;
  assign w_out_fire  = w_main_v & out_ready & w_adv;
  assign w_main_free = ~w_main_v | w_out_fire;

  // Main refills from skid first to keep FIFO order, otherwise from input.
  assign w_main_in   = w_skid_v ? w_skid_d : in_data;
  assign w_main_load = w_adv & w_main_free & (w_skid_v | w_in_fire);
  assign w_main_drop = w_adv & w_main_free & ~w_skid_v & ~w_in_fire;
  assign w_skid_load = w_adv & ~w_main_free & w_in_fire;
  assign w_skid_drop = w_adv & w_main_free & w_skid_v;

  pipe_skid_entry #(.DATA_W(DATA_W), .BUBBLE(BUBBLE)) u_main (
    .clk     (clk),
    .rst     (rst),
    .i_clear (flush),
    .i_load  (w_main_load),
    .i_drop  (w_main_drop),
    .i_data  (w_main_in),
    .o_valid (w_main_v),
    .o_data  (w_main_d)
  );

  pipe_skid_entry #(.DATA_W(DATA_W), .BUBBLE(BUBBLE)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_clear (flush),
    .i_load  (w_skid_load),
    .i_drop  (w_skid_drop),
    .i_data  (in_data),
    .o_valid (w_skid_v),
    .o_data  (w_skid_d)
  );

  assign out_valid = w_main_v;
  assign out_data  = w_main_d;

`ifdef PIPE_STAGE_REG_PERF_EN
  logic [PERF_CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  // Counters keep running through freeze so stalls are themselves counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_frz | (w_main_v & ~out_ready))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (flush & (w_main_v | w_skid_v))
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign perf_stall_cnt = r_stall_cnt;
  assign perf_flush_cnt = r_flush_cnt;
  assign perf_bubble    = ~w_main_v & ~rst;
`else
  // Plain boundary register: no performance instrumentation.
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: FIFO-queue reference model checked
// every cycle plus directed scenarios with literal expectations.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int                DATA_W = 64;
  localparam logic [DATA_W-1:0] BUBBLE = '0;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic [1:0]        freeze = 2'b00;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
`ifdef PIPE_STAGE_REG_PERF_EN
  logic [31:0]       perf_stall_cnt, perf_flush_cnt;
  logic              perf_bubble;
  logic [31:0]       m_stall = '0, m_flush = '0;
`endif

  int n_checks = 0;
  int n_err    = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DATA_W), .N_FRZ(2), .BUBBLE(BUBBLE)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .freeze    (freeze),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_STAGE_REG_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt),
    .perf_bubble    (perf_bubble)
`endif
  );

  // ---------------- reference model ----------------
  // Stage contents as a FIFO of at most two payloads; out_data is the head,
  // or the last payload that left (BUBBLE after reset/flush) when empty.
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] m_last = '0;

  always @(posedge clk or posedge rst) begin : model
    bit acc;
    if (rst) begin
      exp_q.delete();
      m_last <= BUBBLE;
`ifdef PIPE_STAGE_REG_PERF_EN
      m_stall <= '0;
      m_flush <= '0;
`endif
    end else begin
`ifdef PIPE_STAGE_REG_PERF_EN
      if ((|freeze) || (exp_q.size() != 0 && !out_ready)) m_stall <= m_stall + 1;
      if (flush && exp_q.size() != 0) m_flush <= m_flush + 1;
`endif
      if (flush) begin
        exp_q.delete();
        m_last <= BUBBLE;
      end else if (!(|freeze)) begin
        acc = in_valid && (exp_q.size() < 2);
        if (exp_q.size() != 0 && out_ready) m_last <= exp_q.pop_front();
        if (acc) exp_q.push_back(in_data);
      end
    end
  end

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("cmp_out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() != 0});
    check("cmp_out_data", out_data, (exp_q.size() != 0) ? exp_q[0] : m_last);
    check("cmp_in_ready", {63'd0, in_ready},
          {63'd0, (exp_q.size() < 2) && !(|freeze)});
`ifdef PIPE_STAGE_REG_PERF_EN
    check("cmp_perf_stall", {32'd0, perf_stall_cnt}, {32'd0, m_stall});
    check("cmp_perf_flush", {32'd0, perf_flush_cnt}, {32'd0, m_flush});
    check("cmp_perf_bubble", {63'd0, perf_bubble},
          {63'd0, (exp_q.size() == 0) && !rst});
`endif
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d,
                       input logic ordy, input logic [1:0] frz, input logic fl);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    freeze    = frz;
    flush     = fl;
  endtask

  localparam logic [DATA_W-1:0] P0 = 64'h0000_0004_E3A0_1001;
  localparam logic [DATA_W-1:0] PA = 64'hAAAA_0000_0000_000A;
  localparam logic [DATA_W-1:0] PB = 64'hBBBB_0000_0000_000B;
  localparam logic [DATA_W-1:0] PC = 64'hCCCC_0000_0000_000C;
  localparam logic [DATA_W-1:0] PD = 64'hDDDD_0000_0000_000D;

  initial begin
    // Reset then idle
    tick();
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    rst = 1'b0;
    drive(1'b1, P0, 1'b0, 2'b00, 1'b0);
    tick();
    check("first_valid", {63'd0, out_valid}, 64'd1);
    check("first_data", out_data, P0);
    drive(1'b0, '0, 1'b1, 2'b00, 1'b0);
    tick();
    check("drain_valid", {63'd0, out_valid}, 64'd0);
    check("drain_data_retained", out_data, P0);

    // Back-to-back stream
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 64'(i), 1'b1, 2'b00, 1'b0);
      tick();
      check("stream_data", out_data, 64'(i));
      check("stream_in_ready", {63'd0, in_ready}, 64'd1);
    end
    drive(1'b0, '0, 1'b1, 2'b00, 1'b0);
    tick();

    // Downstream stall, A/B/C delivered in order
    drive(1'b1, PA, 1'b0, 2'b00, 1'b0); tick();
    drive(1'b1, PB, 1'b0, 2'b00, 1'b0); tick();
    drive(1'b1, PC, 1'b0, 2'b00, 1'b0); tick();
    check("stall_in_ready", {63'd0, in_ready}, 64'd0);
    check("stall_head", out_data, PA);
    out_ready = 1'b1; tick();
    check("stall_rel_b", out_data, PB);
    tick();
    check("stall_rel_c", out_data, PC);
    in_valid = 1'b0; tick();
    check("stall_empty", {63'd0, out_valid}, 64'd0);

    // Freeze holds main
    drive(1'b1, PA, 1'b0, 2'b00, 1'b0); tick();
    drive(1'b0, '0, 1'b1, 2'b10, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("frz_data", out_data, PA);
      check("frz_valid", {63'd0, out_valid}, 64'd1);
      check("frz_in_ready", {63'd0, in_ready}, 64'd0);
    end
    freeze = 2'b00; tick();
    check("frz_release", {63'd0, out_valid}, 64'd0);

    // Flush with both entries full and a new input offered
    drive(1'b1, PA, 1'b0, 2'b00, 1'b0); tick();
    drive(1'b1, PB, 1'b0, 2'b00, 1'b0); tick();
    drive(1'b1, PD, 1'b0, 2'b00, 1'b1); tick();
    drive(1'b0, '0, 1'b1, 2'b00, 1'b0);
    check("flush_valid", {63'd0, out_valid}, 64'd0);
    check("flush_data", out_data, BUBBLE);
    check("flush_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    check("flush_no_ghost", {63'd0, out_valid}, 64'd0);

    // Flush beats freeze
    drive(1'b1, PC, 1'b0, 2'b00, 1'b0); tick();
    drive(1'b0, '0, 1'b0, 2'b01, 1'b1); tick();
    check("flushfrz_valid", {63'd0, out_valid}, 64'd0);
    check("flushfrz_data", out_data, BUBBLE);
    drive(1'b0, '0, 1'b0, 2'b00, 1'b0);

    // Asynchronous reset mid-stall
    drive(1'b1, PA, 1'b0, 2'b00, 1'b0); tick();
    drive(1'b1, PB, 1'b0, 2'b00, 1'b0); tick();
    #1 rst = 1'b1;
    #1;
    check("arst_valid", {63'd0, out_valid}, 64'd0);
    check("arst_data", out_data, BUBBLE);
    check("arst_in_ready", {63'd0, in_ready}, 64'd1);
    drive(1'b0, '0, 1'b0, 2'b00, 1'b0);
    tick();
    rst = 1'b0;

    // Mixed traffic, checked by the per-cycle compare
    for (int i = 0; i < 80; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      freeze    = ($urandom_range(0, 7) == 0) ? 2'b01 : 2'b00;
      flush     = ($urandom_range(0, 15) == 0);
      tick();
    end
    drive(1'b0, '0, 1'b1, 2'b00, 1'b0);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
